// File: rtl/vx_credit_tx_if.sv
// Flit/credit bundle between an upstream producer and the credit-based transmitter.
// The master side feeds flits and credit returns; the slave side is the transmitter.
interface vx_credit_tx_if #(
  parameter int unsigned DATAW   = 32,
  parameter int unsigned CREDITW = 3
);

  logic               in_valid;
  logic [DATAW-1:0]   in_data;
  logic               in_ready;
  logic               out_valid;
  logic [DATAW-1:0]   out_data;
  logic               crd_ret;
  logic [CREDITW-1:0] credits;
  logic               idle;
  logic               err;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output crd_ret,
    input  credits,
    input  idle,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  crd_ret,
    output credits,
    output idle,
    output err
  );

endinterface

// File: rtl/vx_credit_tx.sv
// Credit-based flit transmitter: accepts a flit while a receiver credit is available,
// emits it one cycle later as a single-cycle pulse, and tracks credits returned by the
// receiver. A credit returned while all credits are already home is a sticky error.
module vx_credit_tx #(
  parameter int unsigned DATAW   = 32,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CREDITW = $clog2(CREDITS + 1)
) (
  input logic           clk,
  input logic           reset,
  vx_credit_tx_if.slave bus
);

  localparam logic [CREDITW-1:0] MaxCredits = CREDITW'(CREDITS);
  localparam logic [CREDITW-1:0] OneCredit  = CREDITW'(1);

  if (CREDITS < 1 || CREDITS > 255) begin : g_bad_credits
    $error("vx_credit_tx: CREDITS must be in 1..255");
  end

  logic [CREDITW-1:0] credits_q, credits_d;
  logic               valid_q, valid_d;
  logic [DATAW-1:0]   data_q, data_d;
  logic               err_q, err_d;
  logic               idle_q, idle_d;

  logic ready;
  logic accept;
  logic overflow;

  // Ready comes only from the credit register; a credit returned this cycle is not
  // usable until it has been registered. Reset holds ready low.
  assign ready  = (credits_q != '0) && !reset;
  assign accept = bus.in_valid && ready;

  // Next-state: credit accounting, output register load and sticky error.
  always_comb begin
    credits_d = credits_q;
    overflow  = 1'b0;
    case ({accept, bus.crd_ret})
      2'b10: credits_d = credits_q - OneCredit;
      2'b01: begin
        // Saturate instead of wrapping; the extra return is flagged as an error.
        if (credits_q == MaxCredits) begin
          overflow = 1'b1;
        end else begin
          credits_d = credits_q + OneCredit;
        end
      end
      // Accept plus return cancels out, even with all credits home.
      default: credits_d = credits_q;
    endcase

    valid_d = accept;
    data_d  = accept ? bus.in_data : data_q;
    err_d   = err_q || overflow;
    idle_d  = (credits_d == MaxCredits) && !valid_d;
  end

  // State registers with synchronous, active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q <= MaxCredits;
      valid_q   <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      credits_q <= credits_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      err_q     <= err_d;
      idle_q    <= idle_d;
    end
  end

  // Outputs are the registers, forced to their reset values while reset is high so
  // that a flit registered just before reset is dropped in the reset cycle itself.
  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q && !reset;
  assign bus.out_data  = reset ? '0 : data_q;
  assign bus.credits   = reset ? MaxCredits : credits_q;
  assign bus.err       = err_q && !reset;
  assign bus.idle      = idle_q || reset;

  // A credit returned with nothing outstanding indicates a receiver protocol bug.
  a_no_credit_overflow : assert property (@(posedge clk) disable iff (reset) !overflow)
    else $warning("vx_credit_tx: credit returned while all credits were home");

  // The credit register must never exceed the receiver depth.
  a_credits_in_range : assert property (@(posedge clk) disable iff (reset)
    credits_q <= MaxCredits);

  // Accepting at zero credits would overrun the receiver buffer.
  a_no_accept_at_zero : assert property (@(posedge clk) disable iff (reset)
    !(accept && credits_q == '0));

endmodule

// File: tb/tb_vx_credit_tx.sv
// Self-checking bench for vx_credit_tx (CREDITS=4, DATAW=32): a table of per-cycle
// inputs and expected registered outputs, a payload scoreboard, and a hand-written
// reset-during-traffic sequence.
module tb_vx_credit_tx;

  localparam int unsigned DATAW   = 32;
  localparam int unsigned CREDITS = 4;
  localparam int unsigned CREDITW = 3;
  localparam int          NVEC    = 23;

  logic clk;
  logic reset;

  vx_credit_tx_if #(.DATAW(DATAW), .CREDITW(CREDITW)) bus ();

  vx_credit_tx #(
    .DATAW  (DATAW),
    .CREDITS(CREDITS),
    .CREDITW(CREDITW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               rst;
    logic               iv;
    logic [DATAW-1:0]   data;
    logic               ret;
    logic               e_rdy;
    logic [CREDITW-1:0] e_cred;
    logic               e_vld;
    logic               e_idle;
    logic               e_err;
  } vec_t;

  vec_t             vecs [NVEC];
  logic [DATAW-1:0] sb [$];
  logic [DATAW-1:0] last_data;
  logic [DATAW-1:0] exp_data;
  logic [CREDITW-1:0] prev_cred;
  logic             exp_pre;
  int               checks;
  int               errors;

  task automatic chk(input string name, input logic [DATAW-1:0] act,
                     input logic [DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample after an edge: on a pulse, the payload must be the oldest expected flit;
  // otherwise out_data must hold its previous value.
  task automatic check_output();
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        exp_data = sb.pop_front();
        chk("out_data", bus.out_data, exp_data);
        last_data = exp_data;
      end
    end else begin
      chk("out_data_hold", bus.out_data, last_data);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_data = '0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.crd_ret  = 1'b0;

    //          rst iv data          ret  rdy cred  vld idle err
    vecs[0]  = '{1, 0, 32'h0000_0000, 0,   0, 3'd4, 0,  1,   0}; // reset
    vecs[1]  = '{1, 1, 32'h0000_00FF, 1,   0, 3'd4, 0,  1,   0}; // reset ignores inputs
    vecs[2]  = '{0, 0, 32'h0000_0000, 0,   1, 3'd4, 0,  1,   0}; // released, quiet
    vecs[3]  = '{0, 1, 32'h0000_00A0, 0,   1, 3'd3, 1,  0,   0}; // 5 beats, no returns
    vecs[4]  = '{0, 1, 32'h0000_00A1, 0,   1, 3'd2, 1,  0,   0};
    vecs[5]  = '{0, 1, 32'h0000_00A2, 0,   1, 3'd1, 1,  0,   0};
    vecs[6]  = '{0, 1, 32'h0000_00A3, 0,   0, 3'd0, 1,  0,   0};
    vecs[7]  = '{0, 1, 32'h0000_00A4, 0,   0, 3'd0, 0,  0,   0}; // A4 stalled
    vecs[8]  = '{0, 1, 32'h0000_00A4, 0,   0, 3'd0, 0,  0,   0};
    vecs[9]  = '{0, 1, 32'h0000_00A4, 1,   1, 3'd1, 0,  0,   0}; // return at zero
    vecs[10] = '{0, 1, 32'h0000_00A4, 0,   0, 3'd0, 1,  0,   0}; // A4 sent
    vecs[11] = '{0, 0, 32'h0000_0000, 1,   1, 3'd1, 0,  0,   0};
    vecs[12] = '{0, 0, 32'h0000_0000, 1,   1, 3'd2, 0,  0,   0};
    vecs[13] = '{0, 1, 32'h0000_00B0, 1,   1, 3'd2, 1,  0,   0}; // accept + return
    vecs[14] = '{0, 1, 32'h0000_00B1, 1,   1, 3'd2, 1,  0,   0};
    vecs[15] = '{0, 1, 32'h0000_00B2, 1,   1, 3'd2, 1,  0,   0};
    vecs[16] = '{0, 0, 32'h0000_0000, 0,   1, 3'd2, 0,  0,   0};
    vecs[17] = '{0, 0, 32'h0000_0000, 1,   1, 3'd3, 0,  0,   0};
    vecs[18] = '{0, 0, 32'h0000_0000, 1,   1, 3'd4, 0,  1,   0}; // all home
    vecs[19] = '{0, 0, 32'h0000_0000, 1,   1, 3'd4, 0,  1,   1}; // overflow
    vecs[20] = '{0, 1, 32'h0000_00C0, 1,   1, 3'd4, 1,  0,   1}; // legal at full
    vecs[21] = '{0, 1, 32'h0000_00C1, 0,   1, 3'd3, 1,  0,   1}; // err sticky
    vecs[22] = '{0, 0, 32'h0000_0000, 1,   1, 3'd4, 0,  1,   1};

    prev_cred = 3'd4;
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      reset        = vecs[i].rst;
      bus.in_valid = vecs[i].iv;
      bus.in_data  = vecs[i].data;
      bus.crd_ret  = vecs[i].ret;
      #1;
      // in_ready before the edge depends only on the registered credit count.
      exp_pre = !vecs[i].rst && (prev_cred != 3'd0);
      chk($sformatf("in_ready_pre[%0d]", i), {31'b0, bus.in_ready}, {31'b0, exp_pre});
      if (vecs[i].rst) begin
        sb.delete();
        last_data = '0;
      end else if (vecs[i].iv && exp_pre) begin
        sb.push_back(vecs[i].data);
      end

      @(posedge clk);
      #1;
      chk($sformatf("in_ready[%0d]", i), {31'b0, bus.in_ready}, {31'b0, vecs[i].e_rdy});
      chk($sformatf("credits[%0d]", i), {29'b0, bus.credits}, {29'b0, vecs[i].e_cred});
      chk($sformatf("out_valid[%0d]", i), {31'b0, bus.out_valid}, {31'b0, vecs[i].e_vld});
      chk($sformatf("idle[%0d]", i), {31'b0, bus.idle}, {31'b0, vecs[i].e_idle});
      chk($sformatf("err[%0d]", i), {31'b0, bus.err}, {31'b0, vecs[i].e_err});
      check_output();
      prev_cred = vecs[i].e_cred;
    end

    // Reset mid-traffic: reach credits=1 with a flit registered, then reset.
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.crd_ret  = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    sb.delete();
    last_data = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_00D0 + k;
      sb.push_back(32'h0000_00D0 + k);
      @(posedge clk);
      #1;
      chk($sformatf("d_out_valid[%0d]", k), {31'b0, bus.out_valid}, 32'd1);
      check_output();
    end
    chk("d_credits", {29'b0, bus.credits}, 32'd1);

    @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_credits", {29'b0, bus.credits}, 32'd4);
    chk("rst_idle", {31'b0, bus.idle}, 32'd1);
    chk("rst_err", {31'b0, bus.err}, 32'd0);
    sb.delete();
    last_data = '0;
    @(posedge clk);
    #1;
    chk("rst2_out_valid", {31'b0, bus.out_valid}, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("rel_credits", {29'b0, bus.credits}, 32'd4);
    chk("rel_idle", {31'b0, bus.idle}, 32'd1);
    chk("rel_err", {31'b0, bus.err}, 32'd0);
    chk("rel_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rel_in_ready2", {31'b0, bus.in_ready}, 32'd1);

    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
